// File: rtl/mips_control_unit.sv
// Multicycle main control FSM for the MIPS core: decodes opcode/funct and drives
// every datapath enable and select as a Moore function of state (PCen also uses zero).
module mips_control_unit #(
  parameter int STATE_WIDTH   = 4,
  parameter int ALUCTRL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic                     zero,
  output logic                     PCen,
  output logic                     IorD,
  output logic                     Page,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     DRWrite,
  output logic                     RegDst,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [ALUCTRL_WIDTH-1:0] ALUControl,
  output logic                     ALU_en,
  output logic                     PCSrc,
  output logic [STATE_WIDTH-1:0]   state
);

  localparam logic [STATE_WIDTH-1:0] S_IDLE    = 'd0;
  localparam logic [STATE_WIDTH-1:0] S_FETCH   = 'd1;
  localparam logic [STATE_WIDTH-1:0] S_DECODE  = 'd2;
  localparam logic [STATE_WIDTH-1:0] S_EXECUTE = 'd3;
  localparam logic [STATE_WIDTH-1:0] S_ALUWB   = 'd4;
  localparam logic [STATE_WIDTH-1:0] S_MEMADR  = 'd5;
  localparam logic [STATE_WIDTH-1:0] S_MEMRD   = 'd6;
  localparam logic [STATE_WIDTH-1:0] S_MEMWB   = 'd7;
  localparam logic [STATE_WIDTH-1:0] S_MEMWR   = 'd8;
  localparam logic [STATE_WIDTH-1:0] S_BRANCH  = 'd9;
  localparam logic [STATE_WIDTH-1:0] S_ADDIEX  = 'd10;
  localparam logic [STATE_WIDTH-1:0] S_ADDIWB  = 'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = 'd0;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = 'd1;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = 'd2;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = 'd3;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_NOR = 'd4;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = 'd5;

  logic [STATE_WIDTH-1:0]   state_q, state_d;
  logic [ALUCTRL_WIDTH-1:0] funct_alu;
  logic                     funct_ok;

  assign state = state_q;

  // R-type funct decode; unknown functs fall back to FETCH without writeback
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h27:   funct_alu = ALU_NOR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = start ? S_FETCH : S_IDLE;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_HALT:       state_d = S_IDLE;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_FETCH;
      S_ALUWB:   state_d = S_FETCH;
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCen       = 1'b0;
    IorD       = 1'b0;
    Page       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    DRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ALU_en     = 1'b0;
    PCSrc      = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCen    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        ALU_en  = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        ALU_en     = 1'b1;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALU_en  = 1'b1;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        Page    = 1'b1;
        DRWrite = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        Page     = 1'b1;
        MemWrite = 1'b1;
      end
      // ALUout keeps the target computed in DECODE; the ALU does the compare
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        PCen       = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Scoreboard bench for mips_control_unit: expected state/controls are queued as
// each cycle is driven and compared at the following falling edge.
module tb_mips_control_unit;

  logic       clk = 1'b0;
  logic       reset, start, zero;
  logic [5:0] opcode, funct;
  logic       PCen, IorD, Page, MemWrite, IRWrite, DRWrite, RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA, ALU_en, PCSrc;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl, state;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_control_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .zero(zero), .PCen(PCen), .IorD(IorD), .Page(Page), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .DRWrite(DRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ALU_en(ALU_en), .PCSrc(PCSrc), .state(state)
  );

  wire [17:0] obs = {PCen, IorD, Page, MemWrite, IRWrite, DRWrite, RegDst, MemtoReg,
                     RegWrite, ALUSrcA, ALUSrcB, ALUControl, ALU_en, PCSrc};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Control word each state should present, written from the state table
  function automatic logic [17:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
    logic pcen, iord, page, mw, irw, drw, rdst, m2r, rw, srca, en, pcsrc;
    logic [1:0] srcb;
    logic [3:0] alu;
    {pcen, iord, page, mw, irw, drw, rdst, m2r, rw, srca, en, pcsrc} = '0;
    srcb = 2'b00;
    alu  = 4'd0;
    case (st)
      4'd1:  begin irw = 1; srcb = 2'b01; pcen = 1; end
      4'd2:  begin srcb = 2'b10; en = 1; end
      4'd3: begin
        srca = 1; en = 1;
        case (fn)
          6'h22: alu = 4'd1;
          6'h24: alu = 4'd2;
          6'h25: alu = 4'd3;
          6'h27: alu = 4'd4;
          6'h2A: alu = 4'd5;
          default: alu = 4'd0;
        endcase
      end
      4'd4:  begin rdst = 1; rw = 1; end
      4'd5, 4'd10: begin srca = 1; srcb = 2'b10; en = 1; end
      4'd6:  begin iord = 1; page = 1; drw = 1; end
      4'd7:  begin m2r = 1; rw = 1; end
      4'd8:  begin iord = 1; page = 1; mw = 1; end
      4'd9:  begin srca = 1; alu = 4'd1; pcsrc = 1; pcen = (op == 6'h04) ? z : !z; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcen, iord, page, mw, irw, drw, rdst, m2r, rw, srca, srcb, alu, en, pcsrc};
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(obs), 32'(e.ctrl));
      chk("mw_rw_excl", 32'(MemWrite & RegWrite), 32'd0);
    end
  end

  // Called at posedge+1; the cycle under way should be in state es
  task automatic expect_cycle(input logic [3:0] es);
    sb.push_back('{st: es, ctrl: model(es, opcode, funct, zero)});
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  // seq holds the expected state walk, one nibble per cycle, oldest first
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [31:0] seq, input int n);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = n - 1; i >= 0; i--) expect_cycle(seq[4*i +: 4]);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
    #2;
    @(posedge clk); #1;
    repeat (5) expect_cycle(4'd0);
    reset = 1'b1;
    expect_cycle(4'd0);
    start = 1'b1;
    expect_cycle(4'd0);
    start = 1'b0;
    instr(6'h00, 6'h22, 1'b0, 32'h1234, 4);
    instr(6'h23, 6'h00, 1'b0, 32'h12567, 5);
    instr(6'h2B, 6'h00, 1'b0, 32'h1258, 4);
    instr(6'h04, 6'h00, 1'b1, 32'h129, 3);
    instr(6'h04, 6'h00, 1'b0, 32'h129, 3);
    instr(6'h05, 6'h00, 1'b1, 32'h129, 3);
    instr(6'h05, 6'h00, 1'b0, 32'h129, 3);
    instr(6'h08, 6'h00, 1'b0, 32'h12AB, 4);
    instr(6'h00, 6'h20, 1'b0, 32'h1234, 4);
    instr(6'h00, 6'h24, 1'b0, 32'h1234, 4);
    instr(6'h00, 6'h25, 1'b0, 32'h1234, 4);
    instr(6'h00, 6'h27, 1'b0, 32'h1234, 4);
    instr(6'h00, 6'h2A, 1'b1, 32'h1234, 4);
    instr(6'h00, 6'h3F, 1'b0, 32'h123, 3);
    instr(6'h3A, 6'h00, 1'b0, 32'h12, 2);
    // start held high: ignored while running, refetches straight after HALT
    start = 1'b1;
    instr(6'h08, 6'h00, 1'b0, 32'h12AB, 4);
    instr(6'h3F, 6'h00, 1'b0, 32'h120, 3);
    start = 1'b0;
    instr(6'h3F, 6'h00, 1'b0, 32'h120, 3);
    expect_cycle(4'd0);
    expect_cycle(4'd0);
    start = 1'b1;
    expect_cycle(4'd0);
    start = 1'b0;
    // lw aborted by an asynchronous reset while in MEMRD
    instr(6'h23, 6'h00, 1'b0, 32'h125, 3);
    sb.push_back('{st: 4'd6, ctrl: model(4'd6, opcode, funct, zero)});
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_ctrl", 32'(obs), 32'd0);
    @(posedge clk); #1;
    expect_cycle(4'd0);
    reset = 1'b1;
    expect_cycle(4'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
